// File: rtl/rvecc_pkg.sv
// Shared types and SECDED helpers for the ECC scrub controller and its decoder.
// Latency: n/a (package, combinational helper functions only).
// Backpressure: n/a.
//
// Word format is {ecc[6:0], data[31:0]}. ecc[5:0] is a Hamming code over the
// data bits placed at the non-power-of-two codeword positions 3,5,6,7,9,...,38.
// ecc[6] makes the overall parity of the 39-bit word even.
package rvecc_pkg;

    localparam int DATA_W = 32;
    localparam int ECC_W  = 7;
    localparam int WORD_W = DATA_W + ECC_W;

    typedef struct packed {
        logic [ECC_W-1:0]  ecc;
        logic [DATA_W-1:0] data;
    } ecc_word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        CHK    = 2'd2,
        WB_REQ = 2'd3
    } scrub_state_e;

    // Hamming codeword position of data bit idx (skips powers of two).
    function automatic logic [5:0] ham_pos(input int idx);
        logic [5:0] pos;
        int         n;
        pos = '0;
        n   = 0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pos = 6'(p);
                n++;
            end
        end
        return pos;
    endfunction

    // XOR of the codeword positions of all set data bits.
    function automatic logic [5:0] ham_syndrome(input logic [DATA_W-1:0] data);
        logic [5:0] s;
        s = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (data[j]) s = s ^ ham_pos(j);
        end
        return s;
    endfunction

    function automatic logic [ECC_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
        logic [5:0] s;
        s = ham_syndrome(data);
        return {(^data) ^ (^s), s};
    endfunction

endpackage

// File: rtl/rvecc_decode.sv
// SECDED (39,32) decoder: flags single/double errors and returns corrected data.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
//
// Ports: en gates the error flags; sed_ded=1 selects detect-only mode (any
// error reported as double, no correction); din/ecc_in is the raw word;
// dout/ecc_out is the corrected word with freshly computed check bits.
module rvecc_decode
    import rvecc_pkg::*;
(
    input  logic              en,
    input  logic              sed_ded,
    input  logic [DATA_W-1:0] din,
    input  logic [ECC_W-1:0]  ecc_in,
    output logic [DATA_W-1:0] dout,
    output logic [ECC_W-1:0]  ecc_out,
    output logic              single_err,
    output logic              double_err
);

    logic [5:0]        syn;
    logic              parity;
    logic [DATA_W-1:0] fixed;

    always_comb begin
        syn    = ham_syndrome(din) ^ ecc_in[5:0];
        parity = ^{ecc_in, din};
        fixed  = din;
        // A syndrome that names a check-bit position (or zero) leaves data alone.
        for (int j = 0; j < DATA_W; j++) begin
            if (ham_pos(j) == syn) fixed[j] = ~din[j];
        end

        single_err = 1'b0;
        double_err = 1'b0;
        dout       = din;
        if (en) begin
            if (sed_ded) begin
                double_err = (syn != 6'd0) || parity;
            end else begin
                // Odd overall parity: one flipped bit, correctable.
                // Even parity with nonzero syndrome: two flipped bits.
                single_err = parity;
                double_err = !parity && (syn != 6'd0);
                if (parity) dout = fixed;
            end
        end
        // Recomputing the check bits also repairs an error in ecc itself.
        ecc_out = ecc_encode(dout);
    end

endmodule

// File: rtl/rvecc_scrub_ctrl.sv
// Background ECC scrubber and single-port SRAM arbiter (functional port vs scrub engine).
// Latency: functional grant combinational, read data the cycle after the grant.
// Backpressure: func_ready low only when the scrubber takes the port; scrubber yields at most MAX_DEFER cycles.
//
// Ports: func_* is the functional requester (valid/ready, 1-cycle read return);
// mem_* drives the SRAM macro (1-cycle read latency); sec_cnt/ded_cnt/ded_addr
// log scrub results; pass_done pulses after the last address is retired.
module rvecc_scrub_ctrl
    import rvecc_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DEPTH     = 1024,
    parameter int INTERVAL  = 256,
    parameter int MAX_DEFER = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              cnt_clr,
    input  logic              func_valid,
    input  logic              func_we,
    input  logic [AW-1:0]     func_addr,
    input  logic [WORD_W-1:0] func_wdata,
    output logic              func_ready,
    output logic              func_rvalid,
    output logic [WORD_W-1:0] func_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic [AW-1:0]     ded_addr,
    output logic              pass_done
);

    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam logic [IW-1:0] INT_RELOAD = IW'(INTERVAL - 1);
    localparam logic [DW-1:0] DEFER_MAX  = DW'(MAX_DEFER);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

    scrub_state_e      state, state_nxt;
    logic [AW-1:0]     scrub_addr;
    logic [IW-1:0]     int_cnt;
    logic [DW-1:0]     defer_cnt;
    logic              conflict;
    ecc_word_t         corr_word;

    ecc_word_t         rd_word;
    logic [DATA_W-1:0] dec_data;
    logic [ECC_W-1:0]  dec_ecc;
    logic              dec_single;
    logic              dec_double;

    logic scrub_req, scrub_take, func_grant, func_wr_hit;
    logic advance, sec_inc, ded_hit, corr_load;
    logic defer_inc, defer_clr, int_dec, int_reload;

    assign rd_word = mem_rdata;

    rvecc_decode u_decode (
        .en         (state == CHK),
        .sed_ded    (1'b0),
        .din        (rd_word.data),
        .ecc_in     (rd_word.ecc),
        .dout       (dec_data),
        .ecc_out    (dec_ecc),
        .single_err (dec_single),
        .double_err (dec_double)
    );

    // A pending writeback that was overtaken by a functional write needs no port.
    assign scrub_req   = (state == RD_REQ) || ((state == WB_REQ) && !conflict);
    assign scrub_take  = scrub_req && (!func_valid || (defer_cnt == DEFER_MAX));
    assign func_grant  = func_valid && !scrub_take;
    assign func_wr_hit = func_grant && func_we && (func_addr == scrub_addr);
    assign func_rdata  = func_rvalid ? mem_rdata : '0;

    always_comb begin
        state_nxt  = state;
        advance    = 1'b0;
        sec_inc    = 1'b0;
        ded_hit    = 1'b0;
        corr_load  = 1'b0;
        defer_inc  = 1'b0;
        defer_clr  = 1'b0;
        int_dec    = 1'b0;
        int_reload = 1'b0;
        func_ready = func_grant;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (scrub_take) begin
            mem_en    = 1'b1;
            mem_we    = (state == WB_REQ);
            mem_addr  = scrub_addr;
            mem_wdata = (state == WB_REQ) ? corr_word : '0;
        end else if (func_grant) begin
            mem_en    = 1'b1;
            mem_we    = func_we;
            mem_addr  = func_addr;
            mem_wdata = func_wdata;
        end

        case (state)
            IDLE: begin
                defer_clr = 1'b1;
                if (scrub_en) begin
                    if (int_cnt == '0) begin
                        int_reload = 1'b1;
                        state_nxt  = RD_REQ;
                    end else begin
                        int_dec = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (scrub_take) begin
                    defer_clr = 1'b1;
                    state_nxt = CHK;
                end else begin
                    defer_inc = 1'b1;
                end
            end
            CHK: begin
                if (dec_single) begin
                    corr_load = 1'b1;
                    sec_inc   = 1'b1;
                    state_nxt = WB_REQ;
                end else begin
                    ded_hit   = dec_double;
                    advance   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB_REQ: begin
                if (conflict || scrub_take) begin
                    defer_clr = 1'b1;
                    advance   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    defer_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            scrub_addr  <= '0;
            int_cnt     <= INT_RELOAD;
            defer_cnt   <= '0;
            conflict    <= 1'b0;
            corr_word   <= '0;
            sec_cnt     <= '0;
            ded_cnt     <= '0;
            ded_addr    <= '0;
            pass_done   <= 1'b0;
            func_rvalid <= 1'b0;
        end else begin
            state       <= state_nxt;
            func_rvalid <= func_grant && !func_we;
            pass_done   <= advance && (scrub_addr == LAST_ADDR);

            if (int_reload) begin
                int_cnt <= INT_RELOAD;
            end else if (int_dec) begin
                int_cnt <= int_cnt - IW'(1);
            end

            if (defer_clr) begin
                defer_cnt <= '0;
            end else if (defer_inc && (defer_cnt != DEFER_MAX)) begin
                defer_cnt <= defer_cnt + DW'(1);
            end

            // Newer functional data to the word under repair cancels the writeback.
            if (state_nxt == IDLE) begin
                conflict <= 1'b0;
            end else if (func_wr_hit && ((state == CHK) || (state == WB_REQ))) begin
                conflict <= 1'b1;
            end

            if (advance) begin
                scrub_addr <= (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + AW'(1);
            end

            if (corr_load) begin
                corr_word <= {dec_ecc, dec_data};
            end

            if (cnt_clr) begin
                sec_cnt <= '0;
            end else if (sec_inc && (sec_cnt != '1)) begin
                sec_cnt <= sec_cnt + CNT_W'(1);
            end

            if (cnt_clr) begin
                ded_cnt <= '0;
            end else if (ded_hit && (ded_cnt != '1)) begin
                ded_cnt <= ded_cnt + CNT_W'(1);
            end

            if (ded_hit) begin
                ded_addr <= scrub_addr;
            end
        end
    end

endmodule

// File: tb/tb_rvecc_scrub_ctrl.sv
module tb_rvecc_scrub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT: DEPTH=8, INTERVAL=4, MAX_DEFER=8 ----------------
    logic        rst = 1'b1, scrub_en = 1'b0, cnt_clr = 1'b0;
    logic        func_valid = 1'b0, func_we = 1'b0;
    logic [2:0]  func_addr = '0;
    logic [38:0] func_wdata = '0;
    logic        func_ready, func_rvalid, mem_en, mem_we, pass_done;
    logic [38:0] func_rdata, mem_wdata;
    logic [38:0] mem_rdata = '0;
    logic [2:0]  mem_addr, ded_addr;
    logic [15:0] sec_cnt, ded_cnt;

    rvecc_scrub_ctrl #(.AW(3), .DEPTH(8), .INTERVAL(4), .MAX_DEFER(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .cnt_clr(cnt_clr),
        .func_valid(func_valid), .func_we(func_we), .func_addr(func_addr),
        .func_wdata(func_wdata), .func_ready(func_ready), .func_rvalid(func_rvalid),
        .func_rdata(func_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sec_cnt(sec_cnt),
        .ded_cnt(ded_cnt), .ded_addr(ded_addr), .pass_done(pass_done)
    );

    // ---------------- second DUT: 3-bit counters, constant faulty word ----------------
    logic        rst2 = 1'b1, cnt_clr2 = 1'b0;
    logic        tie0 = 1'b0;
    logic [2:0]  addr0 = '0;
    logic [38:0] word0 = '0;
    logic [38:0] bad2 = '0;
    logic        func_ready2, func_rvalid2, mem_en2, mem_we2, pass_done2;
    logic [38:0] func_rdata2, mem_wdata2;
    logic [2:0]  mem_addr2, ded_addr2;
    logic [2:0]  sec_cnt2, ded_cnt2;

    rvecc_scrub_ctrl #(.AW(3), .DEPTH(8), .INTERVAL(1), .MAX_DEFER(8), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst2), .scrub_en(1'b1), .cnt_clr(cnt_clr2),
        .func_valid(tie0), .func_we(tie0), .func_addr(addr0),
        .func_wdata(word0), .func_ready(func_ready2), .func_rvalid(func_rvalid2),
        .func_rdata(func_rdata2), .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(bad2), .sec_cnt(sec_cnt2),
        .ded_cnt(ded_cnt2), .ded_addr(ded_addr2), .pass_done(pass_done2)
    );

    // ---------------- SRAM model and bus monitors ----------------
    logic [38:0] mem [8];
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [38:0] load_dat = '0;
    logic        mon_clr = 1'b1;
    int          wb_cnt = 0, pd_cnt = 0, rv_cnt = 0, wb2_cnt = 0;
    logic [2:0]  wb_addr = '0;
    logic [38:0] wb_dat = '0;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_dat;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (mon_clr) begin
            wb_cnt <= 0; pd_cnt <= 0; rv_cnt <= 0;
        end else begin
            if (mem_en && mem_we && !(func_valid && func_ready)) begin
                wb_cnt  <= wb_cnt + 1;
                wb_addr <= mem_addr;
                wb_dat  <= mem_wdata;
            end
            if (pass_done)   pd_cnt <= pd_cnt + 1;
            if (func_rvalid) rv_cnt <= rv_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (rst2) wb2_cnt <= 0;
        else if (mem_en2 && mem_we2) wb2_cnt <= wb2_cnt + 1;
    end

    // ---------------- reference helpers ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Clean SECDED encode built as an explicit 38-position Hamming codeword.
    function automatic logic [38:0] tb_encode(input logic [31:0] d);
        logic       cw [1:38];
        logic [6:0] e;
        int         k;
        k = 0;
        for (int p = 1; p <= 38; p++) begin
            if (p == 1 || p == 2 || p == 4 || p == 8 || p == 16 || p == 32) begin
                cw[p] = 1'b0;
            end else begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            e[i] = 1'b0;
            for (int p = 1; p <= 38; p++) if (p[i]) e[i] = e[i] ^ cw[p];
        end
        e[6] = (^d) ^ (^e[5:0]);
        return {e, d};
    endfunction

    logic [38:0] clean [8];
    logic [38:0] flipv [8];

    // Reset the DUT and load clean words XOR the per-address fault mask.
    task automatic prep();
        @(negedge clk);
        rst = 1'b1; scrub_en = 1'b0; cnt_clr = 1'b0; mon_clr = 1'b1;
        func_valid = 1'b0; func_we = 1'b0; func_addr = '0; func_wdata = '0;
        for (int a = 0; a < 8; a++) begin
            clean[a]  = tb_encode($urandom);
            load_en   = 1'b1;
            load_addr = 3'(a);
            load_dat  = clean[a] ^ flipv[a];
            @(negedge clk);
        end
        load_en = 1'b0; mon_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic wait_pass(input string name);
        int n;
        n = 0;
        while (pd_cnt == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({name, " pass_done count"}, 64'(pd_cnt), 64'd1);
        scrub_en = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          addr;
        logic [38:0] flip;
        int          exp_sec;
        int          exp_ded;
        bit          exp_wb;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"clean",      0, 39'h0,                               0, 0, 1'b0};
        vecs[1] = '{"sec_d5",     3, 39'h20,                              1, 0, 1'b1};
        vecs[2] = '{"ded_d0d1",   6, 39'h3,                               0, 1, 1'b0};
        vecs[3] = '{"sec_ecc2",   0, 39'h1 << 34,                         1, 0, 1'b1};
        vecs[4] = '{"sec_ecc6",   7, 39'h1 << 38,                         1, 0, 1'b1};
        vecs[5] = '{"ded_d31e0",  5, (39'h1 << 31) | (39'h1 << 32),       0, 1, 1'b0};
        bad2 = tb_encode(32'hA5A5_0F0F) ^ (39'h1 << 9);
        for (int a = 0; a < 8; a++) flipv[a] = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("reset func_ready", func_ready, 0);
        chk("reset func_rvalid/rdata", {func_rvalid, func_rdata}, 0);
        chk("reset mem bus", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        chk("reset counters", {sec_cnt, ded_cnt, ded_addr, pass_done}, 0);

        // ---- table: one fault per pass, data randomised per run ----
        for (int v = 0; v < 6; v++) begin
            for (int a = 0; a < 8; a++) flipv[a] = '0;
            flipv[vecs[v].addr] = vecs[v].flip;
            prep();
            scrub_en = 1'b1;
            wait_pass(vecs[v].name);
            repeat (2) @(negedge clk);
            chk({vecs[v].name, " sec_cnt"}, 64'(sec_cnt), 64'(vecs[v].exp_sec));
            chk({vecs[v].name, " ded_cnt"}, 64'(ded_cnt), 64'(vecs[v].exp_ded));
            chk({vecs[v].name, " ded_addr"}, 64'(ded_addr), vecs[v].exp_ded != 0 ? 64'(vecs[v].addr) : 64'd0);
            chk({vecs[v].name, " writebacks"}, 64'(wb_cnt), vecs[v].exp_wb ? 64'd1 : 64'd0);
            chk({vecs[v].name, " no func_rvalid"}, 64'(rv_cnt), 64'd0);
            chk({vecs[v].name, " mem word"}, 64'(mem[vecs[v].addr]),
                vecs[v].exp_wb ? 64'(clean[vecs[v].addr]) : 64'(clean[vecs[v].addr] ^ vecs[v].flip));
            if (vecs[v].exp_wb) begin
                chk({vecs[v].name, " wb addr"}, 64'(wb_addr), 64'(vecs[v].addr));
                chk({vecs[v].name, " wb word"}, 64'(wb_dat), 64'(clean[vecs[v].addr]));
            end
        end
        for (int a = 0; a < 8; a++) flipv[a] = '0;

        // ---- starvation: functional reads held continuously ----
        begin
            int grants;
            bit denied;
            grants = 0;
            denied = 1'b0;
            prep();
            scrub_en = 1'b1; func_valid = 1'b1; func_we = 1'b0; func_addr = 3'd1;
            for (int i = 0; i < 40 && !denied; i++) begin
                #1;
                if (i == 1) begin
                    chk("starve first read rvalid", func_rvalid, 1);
                    chk("starve first read data", func_rdata, clean[1]);
                end
                if (func_ready) begin
                    grants++;
                    @(negedge clk);
                end else begin
                    denied = 1'b1;
                    chk("starve scrub read bus", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 3'd0});
                end
            end
            chk("starve grants before scrub", 64'(grants), 64'd12);
            @(negedge clk);
            #1;
            chk("starve no rvalid after scrub read", func_rvalid, 0);
            func_valid = 1'b0;
        end

        // ---- write conflict: functional write lands during CHK ----
        begin
            bit          found;
            logic [38:0] newword;
            found = 1'b0;
            newword = tb_encode($urandom);
            flipv[2] = 39'h80;
            prep();
            flipv[2] = '0;
            scrub_en = 1'b1;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge clk);
                #1;
                if (mem_en && !mem_we && mem_addr == 3'd2) found = 1'b1;
            end
            chk("conflict scrub read seen", found, 1);
            @(negedge clk);
            func_valid = 1'b1; func_we = 1'b1; func_addr = 3'd2; func_wdata = newword;
            #1;
            chk("conflict grant in CHK", func_ready, 1);
            @(negedge clk);
            func_valid = 1'b0; func_we = 1'b0;
            wait_pass("conflict");
            repeat (2) @(negedge clk);
            chk("conflict mem holds func word", mem[2], newword);
            chk("conflict sec_cnt", 64'(sec_cnt), 64'd1);
            chk("conflict no writeback", 64'(wb_cnt), 64'd0);
        end

        // ---- randomised pass: faults at even words, random reads of odd words ----
        begin
            int          n_inj;
            bit          exp_pend;
            logic [38:0] exp_val;
            n_inj = 0;
            exp_pend = 1'b0;
            exp_val = '0;
            for (int a = 0; a < 8; a += 2) begin
                if ($urandom_range(0, 1) == 1) begin
                    flipv[a] = 39'h1 << $urandom_range(0, 38);
                    n_inj++;
                end
            end
            prep();
            for (int a = 0; a < 8; a++) flipv[a] = '0;
            scrub_en = 1'b1;
            for (int cyc = 0; cyc < 3000 && pd_cnt == 0; cyc++) begin
                @(negedge clk);
                chk("rand rvalid", func_rvalid, exp_pend);
                if (exp_pend) chk("rand rdata", func_rdata, exp_val);
                func_valid = ($urandom_range(0, 2) == 0);
                func_addr  = {2'($urandom_range(0, 3)), 1'b1};
                #1;
                exp_pend = func_valid && func_ready;
                exp_val  = clean[func_addr];
            end
            func_valid = 1'b0;
            chk("rand pass_done", 64'(pd_cnt), 64'd1);
            scrub_en = 1'b0;
            repeat (3) @(negedge clk);
            chk("rand sec_cnt", 64'(sec_cnt), 64'(n_inj));
            chk("rand ded_cnt", 64'(ded_cnt), 64'd0);
            for (int a = 0; a < 8; a++) chk("rand mem repaired", mem[a], clean[a]);
        end

        // ---- counter saturation and clear priority (3-bit counters) ----
        begin
            bit found;
            @(negedge clk);
            rst2 = 1'b0;
            for (int i = 0; i < 300 && wb2_cnt < 10; i++) @(negedge clk);
            chk("sat writebacks seen", 64'(wb2_cnt >= 10), 64'd1);
            chk("sat sec_cnt at all-ones", 64'(sec_cnt2), 64'd7);
            chk("sat ded_cnt", 64'(ded_cnt2), 64'd0);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                #1;
                if (mem_en2 && !mem_we2) found = 1'b1;
            end
            chk("sat scrub read seen", found, 1);
            @(negedge clk);
            cnt_clr2 = 1'b1;
            @(negedge clk);
            cnt_clr2 = 1'b0;
            #1;
            chk("clr beats increment", 64'(sec_cnt2), 64'd0);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                #1;
                if (mem_en2 && !mem_we2) found = 1'b1;
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("count resumes after clr", 64'(sec_cnt2), 64'd1);
            rst2 = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1);
    end

endmodule
